execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage directly upstream of the write-back stage.
- Accepts one decoded instruction with its read operands, computes the ALU result, and presents a registered result bundle to write-back with a valid/ready handshake.
- Simple ops complete in one cycle. Unsigned 64x64 multiply runs iteratively over 64 cycles and produces a 128-bit product: low half goes to the primary destination, high half to the special destination.
- Bit 0 of every multi-bit bus is the MSB.

Parameters:
- MUL_BITS, 64, multiply iterations (one operand bit per cycle); must equal the operand width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetN  in  1  reset; one clock; reset is synchronous and active-low.
- canExecuteIn  in  1  upstream instruction valid.
- executeReadyOut  out  1  stage can accept an instruction this cycle.
- killIn  in  1  instruction is a terminate marker.
- aluOpIn  in  [0:3]  operation code.
- operand1In  in  [0:63]  first operand.
- operand2In  in  [0:63]  second operand.
- currentRipIn  in  [0:63]  instruction pointer.
- sourceReg1In, sourceReg2In  in  [0:3]  source register codes.
- sourceReg1ValidIn, sourceReg2ValidIn  in  1  source code valid.
- destRegIn  in  [0:3]  primary destination code.
- destRegSpecialIn  in  [0:3]  special destination code (high product half).
- writeBackReadyIn  in  1  write-back consumes the bundle this cycle.
- canWriteBackOut  out  1  output bundle valid.
- killOut  out  1  registered killIn.
- currentRipOut, sourceRegCode1Out, sourceRegCode2Out, sourceRegCode1ValidOut, sourceRegCode2ValidOut, destRegOut, destRegSpecialOut  out  same widths as inputs  registered copies of the inputs.
- destRegSpecialValidOut  out  1  high when the op is MUL.
- aluResultOut  out  [0:63]  primary result.
- aluResultSpecialOut  out  [0:63]  high product half; 0 for non-MUL ops.

Behaviour:
- Reset (resetN low at an edge):
  - All outputs 0; state IDLE; multiply counter and accumulators 0.
  - An in-flight multiply is abandoned; executeReadyOut is 0 during reset.
- States:
  - IDLE: stage available.
  - MUL: multiply iterating.
  - FIN: multiply done, waiting for an output slot.
- Output slot:
  - slotFree = !canWriteBackOut || writeBackReadyIn.
  - A transfer occurs when canWriteBackOut && writeBackReadyIn.
  - On a transfer with no new load, canWriteBackOut goes to 0 next cycle.
- executeReadyOut = (state==IDLE) && slotFree. This is combinational from the state and writeBackReadyIn.
- Accept = canExecuteIn && executeReadyOut. All inputs are captured on the accept edge.
- Single-cycle ops, accepted at edge E:
  - Output bundle loaded at edge E and canWriteBackOut=1 after it.
  - Back-to-back accepts are allowed while write-back keeps ready high (full throughput).
- Op codes:
  - 0 ADD, 1 SUB (operand1-operand2).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR (logical), 7 SAR (arithmetic). Shift amount is operand2[58:63].
  - 8 MOV (result = operand2).
  - 9 MUL.
  - 10-15: result 0.
  - All arithmetic is modulo 2^64; carries are discarded.
- MUL:
  - At the accept edge E0: capture the operands, counter=0, product=0, state→MUL.
  - At each edge in MUL: if the current LSB of the multiplier is 1, add the multiplicand to the upper half. Then shift the 128-bit product/multiplier right by 1 and increment the counter.
  - At the edge where the counter reaches MUL_BITS-1 (E64): state→FIN.
  - In FIN, at the first edge with slotFree: load the bundle (aluResultOut = low 64, aluResultSpecialOut = high 64, destRegSpecialValidOut=1) and state→IDLE.
  - Minimum latency: canWriteBackOut rises after E65.
- killIn: the bundle passes with killOut=1; aluResultOut=0, aluResultSpecialOut=0, destRegSpecialValidOut=0; no multiply is started regardless of aluOpIn.
- Backpressure: while canWriteBackOut=1 and writeBackReadyIn=0, every output holds its value exactly.
- canExecuteIn while not ready is ignored; upstream must hold its inputs.
- Mid-multiply: writeBackReadyIn may drain the previous bundle; no new accept until back in IDLE.

Test Plan:
- Reset, then ADD 5+7, dest 3 with writeBackReadyIn=1 -> canWriteBackOut=1 one edge after accept; aluResultOut=12; destRegOut=3; destRegSpecialValidOut=0.
- SUB 0-1 then SAR 0x8000000000000000 by 4, back-to-back -> results 0xFFFFFFFFFFFFFFFF then 0xF800000000000000 on consecutive cycles; executeReadyOut stays 1.
- MUL 0xFFFFFFFFFFFFFFFF*2, dest 0, special 2 -> 65 edges to valid; aluResultOut=0xFFFFFFFFFFFFFFFE; aluResultSpecialOut=1; destRegSpecialValidOut=1; executeReadyOut=0 throughout.
- ADD held with writeBackReadyIn=0 for 3 cycles, new canExecuteIn asserted -> outputs stable, executeReadyOut=0; when ready rises, the new op is accepted the same edge the old bundle transfers.
- resetN low at iteration 30 of a MUL -> all outputs 0, state IDLE; the next ADD 1+1 completes normally with result 2.
- killIn=1 with aluOpIn=9 -> single-cycle bundle; killOut=1; aluResultOut=0; no multiply latency.

Source files
------------

// File: rtl/execute_stage_if.sv
// Bundle of upstream issue signals and downstream write-back signals for the
// execute stage. The stage itself uses the slave view; whatever drives it
// (decode/write-back, or a bench) uses the master view.
interface execute_stage_if;
  // upstream side
  logic        canExecuteIn;
  logic        executeReadyOut;
  logic        killIn;
  logic [0:3]  aluOpIn;
  logic [0:63] operand1In;
  logic [0:63] operand2In;
  logic [0:63] currentRipIn;
  logic [0:3]  sourceReg1In;
  logic [0:3]  sourceReg2In;
  logic        sourceReg1ValidIn;
  logic        sourceReg2ValidIn;
  logic [0:3]  destRegIn;
  logic [0:3]  destRegSpecialIn;

  // write-back side
  logic        writeBackReadyIn;
  logic        canWriteBackOut;
  logic        killOut;
  logic [0:63] currentRipOut;
  logic [0:3]  sourceRegCode1Out;
  logic [0:3]  sourceRegCode2Out;
  logic        sourceRegCode1ValidOut;
  logic        sourceRegCode2ValidOut;
  logic [0:3]  destRegOut;
  logic [0:3]  destRegSpecialOut;
  logic        destRegSpecialValidOut;
  logic [0:63] aluResultOut;
  logic [0:63] aluResultSpecialOut;

  modport slave (
    input  canExecuteIn, killIn, aluOpIn, operand1In, operand2In, currentRipIn,
           sourceReg1In, sourceReg2In, sourceReg1ValidIn, sourceReg2ValidIn,
           destRegIn, destRegSpecialIn, writeBackReadyIn,
    output executeReadyOut, canWriteBackOut, killOut, currentRipOut,
           sourceRegCode1Out, sourceRegCode2Out, sourceRegCode1ValidOut,
           sourceRegCode2ValidOut, destRegOut, destRegSpecialOut,
           destRegSpecialValidOut, aluResultOut, aluResultSpecialOut
  );

  modport master (
    output canExecuteIn, killIn, aluOpIn, operand1In, operand2In, currentRipIn,
           sourceReg1In, sourceReg2In, sourceReg1ValidIn, sourceReg2ValidIn,
           destRegIn, destRegSpecialIn, writeBackReadyIn,
    input  executeReadyOut, canWriteBackOut, killOut, currentRipOut,
           sourceRegCode1Out, sourceRegCode2Out, sourceRegCode1ValidOut,
           sourceRegCode2ValidOut, destRegOut, destRegSpecialOut,
           destRegSpecialValidOut, aluResultOut, aluResultSpecialOut
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage feeding write-back. Single-cycle ALU ops go straight into the
// registered output bundle; unsigned 64x64 multiply runs as a shift-add loop
// (one multiplier bit per cycle) and lands in the bundle once it finishes.
// Bit 0 of every bus is the MSB, so bit 63 of a 64-bit value is its LSB.
module execute_stage #(
  parameter int MUL_BITS = 64
) (
  input logic clk,
  input logic resetN,
  execute_stage_if.slave bus
);

  typedef enum logic [0:1] {IDLE, MUL, FIN} stateT;

  localparam logic [0:3] OP_ADD = 4'd0;
  localparam logic [0:3] OP_SUB = 4'd1;
  localparam logic [0:3] OP_AND = 4'd2;
  localparam logic [0:3] OP_OR  = 4'd3;
  localparam logic [0:3] OP_XOR = 4'd4;
  localparam logic [0:3] OP_SHL = 4'd5;
  localparam logic [0:3] OP_SHR = 4'd6;
  localparam logic [0:3] OP_SAR = 4'd7;
  localparam logic [0:3] OP_MOV = 4'd8;
  localparam logic [0:3] OP_MUL = 4'd9;

  stateT       state;
  stateT       nextState;

  logic        slotFree;
  logic        transfer;
  logic        accept;
  logic        isMulOp;
  logic        lastIter;
  logic        startMul;
  logic        loadSingle;
  logic        loadMul;
  logic        iterate;

  logic [0:5]  shiftAmount;
  logic [0:63] aluResult;

  // multiply datapath: prodHi accumulates, prodLo starts as the multiplier
  // and fills with product bits as the pair shifts right
  logic [0:63] multiplicand;
  logic [0:63] prodHi;
  logic [0:63] prodLo;
  logic [0:64] mulSum;
  logic [0:6]  mulCount;

  // metadata of the multiply in flight, held until the result is loaded
  logic [0:63] pendRip;
  logic [0:3]  pendSrc1;
  logic [0:3]  pendSrc2;
  logic        pendSrc1Valid;
  logic        pendSrc2Valid;
  logic [0:3]  pendDest;
  logic [0:3]  pendDestSpecial;

  assign slotFree            = !bus.canWriteBackOut || bus.writeBackReadyIn;
  assign transfer            = bus.canWriteBackOut && bus.writeBackReadyIn;
  assign bus.executeReadyOut = resetN && (state == IDLE) && slotFree;
  assign accept              = bus.canExecuteIn && bus.executeReadyOut;
  assign isMulOp             = !bus.killIn && (bus.aluOpIn == OP_MUL);
  assign lastIter            = (mulCount == 7'(MUL_BITS - 1));
  assign shiftAmount         = bus.operand2In[58:63];

  // single-cycle ALU result for the instruction currently offered
  always_comb begin
    aluResult = '0;
    case (bus.aluOpIn)
      OP_ADD:  aluResult = bus.operand1In + bus.operand2In;
      OP_SUB:  aluResult = bus.operand1In - bus.operand2In;
      OP_AND:  aluResult = bus.operand1In & bus.operand2In;
      OP_OR:   aluResult = bus.operand1In | bus.operand2In;
      OP_XOR:  aluResult = bus.operand1In ^ bus.operand2In;
      OP_SHL:  aluResult = bus.operand1In << shiftAmount;
      OP_SHR:  aluResult = bus.operand1In >> shiftAmount;
      OP_SAR:  aluResult = 64'($signed(bus.operand1In) >>> shiftAmount);
      OP_MOV:  aluResult = bus.operand2In;
      default: aluResult = '0;
    endcase
  end

  // one shift-add step; the 65th bit keeps the carry so it shifts into prodHi
  always_comb begin
    mulSum = {1'b0, prodHi} + (prodLo[63] ? {1'b0, multiplicand} : 65'd0);
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // next-state and datapath control
  always_comb begin
    nextState  = state;
    startMul   = 1'b0;
    loadSingle = 1'b0;
    loadMul    = 1'b0;
    iterate    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (isMulOp) begin
            startMul  = 1'b1;
            nextState = MUL;
          end else begin
            loadSingle = 1'b1;
          end
        end
      end
      MUL: begin
        iterate = 1'b1;
        if (lastIter) begin
          nextState = FIN;
        end
      end
      FIN: begin
        if (slotFree) begin
          loadMul   = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // output bundle, multiply accumulators and pending metadata
  always_ff @(posedge clk) begin
    if (!resetN) begin
      bus.canWriteBackOut        <= 1'b0;
      bus.killOut                <= 1'b0;
      bus.currentRipOut          <= '0;
      bus.sourceRegCode1Out      <= '0;
      bus.sourceRegCode2Out      <= '0;
      bus.sourceRegCode1ValidOut <= 1'b0;
      bus.sourceRegCode2ValidOut <= 1'b0;
      bus.destRegOut             <= '0;
      bus.destRegSpecialOut      <= '0;
      bus.destRegSpecialValidOut <= 1'b0;
      bus.aluResultOut           <= '0;
      bus.aluResultSpecialOut    <= '0;
      multiplicand               <= '0;
      prodHi                     <= '0;
      prodLo                     <= '0;
      mulCount                   <= '0;
      pendRip                    <= '0;
      pendSrc1                   <= '0;
      pendSrc2                   <= '0;
      pendSrc1Valid              <= 1'b0;
      pendSrc2Valid              <= 1'b0;
      pendDest                   <= '0;
      pendDestSpecial            <= '0;
    end else begin
      if (loadSingle) begin
        bus.canWriteBackOut        <= 1'b1;
        bus.killOut                <= bus.killIn;
        bus.currentRipOut          <= bus.currentRipIn;
        bus.sourceRegCode1Out      <= bus.sourceReg1In;
        bus.sourceRegCode2Out      <= bus.sourceReg2In;
        bus.sourceRegCode1ValidOut <= bus.sourceReg1ValidIn;
        bus.sourceRegCode2ValidOut <= bus.sourceReg2ValidIn;
        bus.destRegOut             <= bus.destRegIn;
        bus.destRegSpecialOut      <= bus.destRegSpecialIn;
        bus.destRegSpecialValidOut <= 1'b0;
        bus.aluResultOut           <= bus.killIn ? 64'd0 : aluResult;
        bus.aluResultSpecialOut    <= '0;
      end else if (loadMul) begin
        bus.canWriteBackOut        <= 1'b1;
        bus.killOut                <= 1'b0;
        bus.currentRipOut          <= pendRip;
        bus.sourceRegCode1Out      <= pendSrc1;
        bus.sourceRegCode2Out      <= pendSrc2;
        bus.sourceRegCode1ValidOut <= pendSrc1Valid;
        bus.sourceRegCode2ValidOut <= pendSrc2Valid;
        bus.destRegOut             <= pendDest;
        bus.destRegSpecialOut      <= pendDestSpecial;
        bus.destRegSpecialValidOut <= 1'b1;
        bus.aluResultOut           <= prodLo;
        bus.aluResultSpecialOut    <= prodHi;
      end else if (transfer) begin
        bus.canWriteBackOut <= 1'b0;
      end

      if (startMul) begin
        multiplicand    <= bus.operand1In;
        prodHi          <= '0;
        prodLo          <= bus.operand2In;
        mulCount        <= '0;
        pendRip         <= bus.currentRipIn;
        pendSrc1        <= bus.sourceReg1In;
        pendSrc2        <= bus.sourceReg2In;
        pendSrc1Valid   <= bus.sourceReg1ValidIn;
        pendSrc2Valid   <= bus.sourceReg2ValidIn;
        pendDest        <= bus.destRegIn;
        pendDestSpecial <= bus.destRegSpecialIn;
      end else if (iterate) begin
        prodHi   <= mulSum[0:63];
        prodLo   <= {mulSum[64], prodLo[0:62]};
        mulCount <= mulCount + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, single-cycle ops, back-to-back
// issue, iterative multiply, backpressure, reset mid-multiply and kill.
module tb_execute_stage;

  logic clk;
  logic resetN;
  int   assertCount;
  int   failCount;

  execute_stage_if bus ();

  execute_stage #(.MUL_BITS(64)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  // free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one instruction to the stage
  task automatic applyStimulus(input logic valid, input logic kill,
                               input logic [3:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [3:0] dest,
                               input logic [3:0] destSpecial,
                               input logic [63:0] rip);
    bus.canExecuteIn      = valid;
    bus.killIn            = kill;
    bus.aluOpIn           = op;
    bus.operand1In        = a;
    bus.operand2In        = b;
    bus.destRegIn         = dest;
    bus.destRegSpecialIn  = destSpecial;
    bus.currentRipIn      = rip;
    bus.sourceReg1In      = 4'd1;
    bus.sourceReg2In      = 4'd2;
    bus.sourceReg1ValidIn = 1'b1;
    bus.sourceReg2ValidIn = 1'b1;
    #1;
  endtask

  // one counted comparison
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  logic [3:0]  tblOp [9];
  logic [63:0] tblA  [9];
  logic [63:0] tblB  [9];
  logic [63:0] tblY  [9];
  logic        sawEarly;
  logic        sawReady;

  initial begin
    assertCount = 0;
    failCount   = 0;

    tblOp[0] = 4'd2;  tblA[0] = 64'hF0F0;             tblB[0] = 64'hFF00; tblY[0] = 64'hF000;
    tblOp[1] = 4'd3;  tblA[1] = 64'hF0F0;             tblB[1] = 64'h0F0F; tblY[1] = 64'hFFFF;
    tblOp[2] = 4'd4;  tblA[2] = 64'hFF;               tblB[2] = 64'h0F;   tblY[2] = 64'hF0;
    tblOp[3] = 4'd5;  tblA[3] = 64'h1;                tblB[3] = 64'd63;   tblY[3] = 64'h8000_0000_0000_0000;
    tblOp[4] = 4'd6;  tblA[4] = 64'h8000_0000_0000_0000; tblB[4] = 64'd4; tblY[4] = 64'h0800_0000_0000_0000;
    tblOp[5] = 4'd6;  tblA[5] = 64'h100;              tblB[5] = 64'h44;   tblY[5] = 64'h10;
    tblOp[6] = 4'd8;  tblA[6] = 64'hDEAD;             tblB[6] = 64'h1234; tblY[6] = 64'h1234;
    tblOp[7] = 4'd12; tblA[7] = 64'h55;               tblB[7] = 64'h66;   tblY[7] = 64'h0;
    tblOp[8] = 4'd0;  tblA[8] = 64'hFFFF_FFFF_FFFF_FFFF; tblB[8] = 64'h1; tblY[8] = 64'h0;

    // reset
    resetN = 1'b0;
    bus.writeBackReadyIn = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
    tick();
    checkOutput("reset canWriteBackOut", 64'(bus.canWriteBackOut), 64'd0);
    checkOutput("reset aluResultOut", bus.aluResultOut, 64'd0);
    checkOutput("reset executeReadyOut", 64'(bus.executeReadyOut), 64'd0);
    resetN = 1'b1;
    #1;
    checkOutput("idle executeReadyOut", 64'(bus.executeReadyOut), 64'd1);

    // ADD 5+7
    $display("[TB] ADD");
    applyStimulus(1'b1, 1'b0, 4'd0, 64'd5, 64'd7, 4'd3, 4'd0, 64'h1000);
    tick();
    checkOutput("add valid", 64'(bus.canWriteBackOut), 64'd1);
    checkOutput("add result", bus.aluResultOut, 64'd12);
    checkOutput("add destReg", 64'(bus.destRegOut), 64'd3);
    checkOutput("add specialValid", 64'(bus.destRegSpecialValidOut), 64'd0);
    checkOutput("add rip", bus.currentRipOut, 64'h1000);
    checkOutput("add src1", 64'(bus.sourceRegCode1Out), 64'd1);

    // SUB then SAR back-to-back
    $display("[TB] SUB/SAR back-to-back");
    applyStimulus(1'b1, 1'b0, 4'd1, 64'd0, 64'd1, 4'd4, 4'd0, 64'h1004);
    tick();
    checkOutput("sub result", bus.aluResultOut, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("sub ready stays", 64'(bus.executeReadyOut), 64'd1);
    applyStimulus(1'b1, 1'b0, 4'd7, 64'h8000_0000_0000_0000, 64'd4, 4'd5, 4'd0, 64'h1008);
    tick();
    checkOutput("sar result", bus.aluResultOut, 64'hF800_0000_0000_0000);
    checkOutput("sar valid", 64'(bus.canWriteBackOut), 64'd1);
    checkOutput("sar rip", bus.currentRipOut, 64'h1008);

    // remaining ops, full throughput
    $display("[TB] op table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, tblOp[i], tblA[i], tblB[i], 4'd6, 4'd0, 64'h2000);
      tick();
      checkOutput($sformatf("table op%0d result", i), bus.aluResultOut, tblY[i]);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    tick();
    checkOutput("drain valid low", 64'(bus.canWriteBackOut), 64'd0);

    // MUL 0xFFFF_FFFF_FFFF_FFFF * 2
    $display("[TB] MUL");
    applyStimulus(1'b1, 1'b0, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd0, 4'd2, 64'h3000);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    sawEarly = 1'b0;
    sawReady = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (bus.canWriteBackOut) sawEarly = 1'b1;
      if (bus.executeReadyOut) sawReady = 1'b1;
      tick();
    end
    if (bus.executeReadyOut) sawReady = 1'b1;
    checkOutput("mul no early valid", 64'(sawEarly), 64'd0);
    checkOutput("mul ready low", 64'(sawReady), 64'd0);
    checkOutput("mul valid before E65", 64'(bus.canWriteBackOut), 64'd0);
    tick();
    checkOutput("mul valid E65", 64'(bus.canWriteBackOut), 64'd1);
    checkOutput("mul low", bus.aluResultOut, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("mul high", bus.aluResultSpecialOut, 64'd1);
    checkOutput("mul specialValid", 64'(bus.destRegSpecialValidOut), 64'd1);
    checkOutput("mul destReg", 64'(bus.destRegOut), 64'd0);
    checkOutput("mul destSpecial", 64'(bus.destRegSpecialOut), 64'd2);
    checkOutput("mul rip", bus.currentRipOut, 64'h3000);
    tick();
    checkOutput("mul drained", 64'(bus.canWriteBackOut), 64'd0);

    // backpressure
    $display("[TB] backpressure");
    bus.writeBackReadyIn = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd0, 64'd10, 64'd20, 4'd5, 4'd0, 64'h4000);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd4, 64'hF0, 64'hFF, 4'd6, 4'd0, 64'h4004);
    checkOutput("bp ready low", 64'(bus.executeReadyOut), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("bp hold result %0d", i), bus.aluResultOut, 64'd30);
      checkOutput($sformatf("bp hold dest %0d", i), 64'(bus.destRegOut), 64'd5);
      checkOutput($sformatf("bp hold valid %0d", i), 64'(bus.canWriteBackOut), 64'd1);
    end
    bus.writeBackReadyIn = 1'b1;
    #1;
    checkOutput("bp ready rises", 64'(bus.executeReadyOut), 64'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    checkOutput("bp new result", bus.aluResultOut, 64'h0F);
    checkOutput("bp new dest", 64'(bus.destRegOut), 64'd6);
    checkOutput("bp new valid", 64'(bus.canWriteBackOut), 64'd1);
    tick();
    checkOutput("bp drained", 64'(bus.canWriteBackOut), 64'd0);

    // reset in the middle of a multiply
    $display("[TB] reset mid-MUL");
    applyStimulus(1'b1, 1'b0, 4'd9, 64'd3, 64'd5, 4'd7, 4'd8, 64'h5000);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    for (int i = 0; i < 30; i++) tick();
    resetN = 1'b0;
    tick();
    checkOutput("midreset result", bus.aluResultOut, 64'd0);
    checkOutput("midreset dest", 64'(bus.destRegOut), 64'd0);
    checkOutput("midreset rip", bus.currentRipOut, 64'd0);
    checkOutput("midreset ready", 64'(bus.executeReadyOut), 64'd0);
    resetN = 1'b1;
    #1;
    checkOutput("postreset ready", 64'(bus.executeReadyOut), 64'd1);
    applyStimulus(1'b1, 1'b0, 4'd0, 64'd1, 64'd1, 4'd9, 4'd0, 64'h6000);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    checkOutput("postreset add", bus.aluResultOut, 64'd2);
    checkOutput("postreset specialValid", 64'(bus.destRegSpecialValidOut), 64'd0);
    sawEarly = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.canWriteBackOut) sawEarly = 1'b1;
    end
    checkOutput("abandoned mul silent", 64'(sawEarly), 64'd0);

    // kill with MUL opcode
    $display("[TB] kill");
    applyStimulus(1'b1, 1'b1, 4'd9, 64'd3, 64'd4, 4'd7, 4'd8, 64'h7000);
    tick();
    applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    checkOutput("kill valid", 64'(bus.canWriteBackOut), 64'd1);
    checkOutput("kill killOut", 64'(bus.killOut), 64'd1);
    checkOutput("kill result", bus.aluResultOut, 64'd0);
    checkOutput("kill special", bus.aluResultSpecialOut, 64'd0);
    checkOutput("kill specialValid", 64'(bus.destRegSpecialValidOut), 64'd0);
    checkOutput("kill ready", 64'(bus.executeReadyOut), 64'd1);
    tick();
    checkOutput("kill drained", 64'(bus.canWriteBackOut), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
